// File: rtl/keypad_scan_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : keypad_scan_if                                            |
// | Purpose  : Signal bundle between the keypad scanner, the physical    |
// |            4x4 matrix and the digit-accumulation stage.              |
// | Signals  : row            - row returns, active-low (from keypad)    |
// |            col            - column drive, active-low (to keypad)     |
// |            key            - last accepted key code, zero-extended    |
// |            button_pressed - one-cycle strobe per accepted press      |
// | Modports : master - scanner side; slave - keypad/consumer side       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface keypad_scan_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [7:0] key;
  logic       button_pressed;

  modport master (
    input  row,
    output col,
    output key,
    output button_pressed
  );

  modport slave (
    output row,
    input  col,
    input  key,
    input  button_pressed
  );
endinterface : keypad_scan_if
`default_nettype wire

// File: rtl/keypad_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : keypad_scan                                               |
// | Purpose  : 4x4 active-low matrix keypad scanner. Drives one column   |
// |            low at a time, synchronizes the row returns, classifies   |
// |            each full scan (none / one key / several keys), debounces |
// |            press and release over DEBOUNCE_SCANS scans, and emits    |
// |            the key code followed one cycle later by a strobe.        |
// | Ports    : hwclk - system clock                                      |
// |            reset - synchronous active-high reset                     |
// |            bus   - keypad_scan_if.master (row/col/key/button_pressed)|
// | Params   : SCAN_DIV       - cycles each column is driven (>= 4)      |
// |            DEBOUNCE_SCANS - identical scans to accept (>= 2)         |
// | Macro    : KEYPAD_DIGIT_FILTER_EN - keys with code > 9 are tracked   |
// |            but never update key nor strobe                           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module keypad_scan #(
  parameter int SCAN_DIV       = 1200,
  parameter int DEBOUNCE_SCANS = 50
) (
  input  logic          hwclk,
  input  logic          reset,
  keypad_scan_if.master bus
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] c_DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] c_CNT_LAST   = CW'(DEBOUNCE_SCANS - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_PRESS_DB   = 2'd1,
    S_HELD       = 2'd2,
    S_RELEASE_DB = 2'd3
  } state_t;

  // Key map: row r, column c -> code.
  function automatic logic [3:0] f_key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] v;
    v = 4'd0;
    case ({r, c})
      4'h0: v = 4'd1;
      4'h1: v = 4'd2;
      4'h2: v = 4'd3;
      4'h3: v = 4'd10;
      4'h4: v = 4'd4;
      4'h5: v = 4'd5;
      4'h6: v = 4'd6;
      4'h7: v = 4'd11;
      4'h8: v = 4'd7;
      4'h9: v = 4'd8;
      4'hA: v = 4'd9;
      4'hB: v = 4'd12;
      4'hC: v = 4'd14;
      4'hD: v = 4'd0;
      4'hE: v = 4'd15;
      4'hF: v = 4'd13;
      default: v = 4'd0;
    endcase
    return v;
  endfunction

  // Row synchronizer
  logic [3:0] r_row_s1;
  logic [3:0] r_row_s2;

  // Scan timing
  logic [DW-1:0] r_dwell;
  logic [1:0]    r_col_idx;

  // Per-scan accumulation: r_hits saturates at 2 (= several keys)
  logic [1:0] r_hits;
  logic [3:0] r_code;

  // Debounce FSM
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]    r_cand, w_cand_nxt;
  logic [3:0]    r_key, w_key_nxt;
  logic          w_strobe_set;
  logic          r_strobe_pend;
  logic          r_button;

  logic       w_sample;
  logic       w_scan_end;
  logic [3:0] w_closed;
  logic [2:0] w_col_cnt;
  logic [1:0] w_row_sel;
  logic [1:0] w_base_hits;
  logic [2:0] w_sum;
  logic [1:0] w_tot;
  logic [3:0] w_tot_code;
  logic       w_res_none;
  logic       w_res_one;
  logic       w_accept_ok;

  always_ff @(posedge hwclk) begin
    if (reset) begin
      r_row_s1 <= 4'hF;
      r_row_s2 <= 4'hF;
    end else begin
      r_row_s1 <= bus.row;
      r_row_s2 <= r_row_s1;
    end
  end

  always_ff @(posedge hwclk) begin
    if (reset) begin
      r_dwell   <= '0;
      r_col_idx <= 2'd0;
    end else if (w_sample) begin
      r_dwell   <= '0;
      r_col_idx <= r_col_idx + 2'd1;
    end else begin
      r_dwell   <= r_dwell + 1'b1;
    end
  end

  assign w_sample   = (r_dwell == c_DWELL_LAST);
  assign w_scan_end = w_sample && (r_col_idx == 2'd3);
  assign bus.col    = ~(4'b0001 << r_col_idx);

  // Closed switches in the column currently driven
  assign w_closed  = ~r_row_s2;
  assign w_col_cnt = {2'b00, w_closed[0]} + {2'b00, w_closed[1]} +
                     {2'b00, w_closed[2]} + {2'b00, w_closed[3]};
  assign w_row_sel = w_closed[0] ? 2'd0 :
                     w_closed[1] ? 2'd1 :
                     w_closed[2] ? 2'd2 : 2'd3;

  // Column 0 starts a fresh scan, so earlier hits are discarded there.
  assign w_base_hits = (r_col_idx == 2'd0) ? 2'd0 : r_hits;
  assign w_sum       = {1'b0, w_base_hits} + w_col_cnt;
  assign w_tot       = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
  // Only meaningful when w_tot == 1: the single hit is either in this
  // column or was recorded in an earlier one.
  assign w_tot_code  = (w_col_cnt == 3'd1) ? f_key_code(w_row_sel, r_col_idx) : r_code;

  always_ff @(posedge hwclk) begin
    if (reset) begin
      r_hits <= 2'd0;
      r_code <= 4'd0;
    end else if (w_sample) begin
      r_hits <= w_tot;
      r_code <= w_tot_code;
    end
  end

  assign w_res_none = (w_tot == 2'd0);
  assign w_res_one  = (w_tot == 2'd1);

`ifdef KEYPAD_DIGIT_FILTER_EN
  assign w_accept_ok = (r_cand <= 4'd9);
`else
  assign w_accept_ok = 1'b1;
`endif

  always_ff @(posedge hwclk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_cand        <= 4'd0;
      r_key         <= 4'd0;
      r_strobe_pend <= 1'b0;
      r_button      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_cand        <= w_cand_nxt;
      r_key         <= w_key_nxt;
      // Two-stage strobe path puts the strobe one cycle behind key.
      r_strobe_pend <= w_strobe_set;
      r_button      <= r_strobe_pend;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_cand_nxt   = r_cand;
    w_key_nxt    = r_key;
    w_strobe_set = 1'b0;
    if (w_scan_end) begin
      case (r_state)
        S_IDLE: begin
          if (w_res_one) begin
            w_cand_nxt  = w_tot_code;
            w_cnt_nxt   = CW'(1);
            w_state_nxt = S_PRESS_DB;
          end
        end
        S_PRESS_DB: begin
          if (w_res_one && (w_tot_code == r_cand)) begin
            if (r_cnt == c_CNT_LAST) begin
              w_cnt_nxt   = '0;
              w_state_nxt = S_HELD;
              if (w_accept_ok) begin
                w_key_nxt    = r_cand;
                w_strobe_set = 1'b1;
              end
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end
        end
        S_HELD: begin
          if (w_res_none) begin
            w_cnt_nxt   = CW'(1);
            w_state_nxt = S_RELEASE_DB;
          end
        end
        S_RELEASE_DB: begin
          if (w_res_none) begin
            if (r_cnt == c_CNT_LAST) begin
              w_cnt_nxt   = '0;
              w_state_nxt = S_IDLE;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_HELD;
          end
        end
        default: begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign bus.key            = {4'h0, r_key};
  assign bus.button_pressed = r_button;

endmodule : keypad_scan
`default_nettype wire
